cpu_line_arbiter: RTL

- Shares one cpu_checker instance between N character-stream sources. Each source emits CPU output lines ("^time@pc: $reg <= data#" / "*addr <= data#").
- Grants the checker one whole line at a time, round-robin, so lines are never interleaved.
- Forwards the granted chars one per clock, captures the checker's format_type after each '#', and tags the result with the source id.
- Sits between the per-source char producers and cpu_checker's char/format_type ports.

---
 rtl/cpu_line_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cpu_line_arbiter.sv
// cpu_line_arbiter: grants one cpu_checker to N char-stream sources,
// one whole line at a time, round-robin, and tags each format_type result.
// Ports: clk, reset (async, active-low); in_char/in_valid/in_ready per
// source; chk_char to the checker, chk_type from it; busy, gnt_src;
// res_valid/res_src/res_type per finished line; abort per broken line.
// Optional: define CHK_MAXLEN_EN to bound lines at MAXLEN chars.
module cpu_line_arbiter #(
   parameter int N      = 2,
   parameter int SW     = (N > 1) ? $clog2(N) : 1,
   parameter int MAXLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [8*N-1:0]  in_char,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [7:0]      chk_char,
   input  logic [1:0]      chk_type,
   output logic            busy,
   output logic [SW-1:0]   gnt_src,
   output logic            res_valid,
   output logic [SW-1:0]   res_src,
   output logic [1:0]      res_type,
   output logic            abort
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] CARET = 8'h5E;
   localparam logic [7:0] HASH  = 8'h23;

   state_t          state, nxt_state;
   logic [SW-1:0]   rr_ptr, nxt_rr, nxt_gnt, sel;
   logic [7:0]      nxt_char, g_char;
   logic            g_valid, found, nxt_abort, line_end, over_len;
   logic            cap1_v, cap2_v;
   logic [SW-1:0]   cap1_src, cap2_src;

   function automatic int rr_idx(input logic [SW-1:0] p, input int k);
      return (int'(p) + k) % N;
   endfunction

   function automatic logic [SW-1:0] next_src(input logic [SW-1:0] s);
      return (int'(s) == N - 1) ? '0 : s + 1'b1;
   endfunction

   assign busy    = (state == GRANT);
   assign g_char  = in_char[{gnt_src, 3'b000} +: 8];
   assign g_valid = in_valid[gnt_src];

   // First '^' source at or after rr_ptr.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && in_valid[rr_idx(rr_ptr, k)] &&
             in_char[8*rr_idx(rr_ptr, k) +: 8] == CARET) begin
            found = 1'b1;
            sel   = SW'(rr_idx(rr_ptr, k));
         end
      end
   end

`ifdef CHK_MAXLEN_EN
   localparam int LW = $clog2(MAXLEN + 1);
   logic [LW-1:0] len;

   // len holds the chars already sent; the next one would be len+1.
   assign over_len = (len == LW'(MAXLEN - 1)) && (g_char != HASH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         len <= '0;
      else if (state == IDLE)
         len <= LW'(1);
      else if (g_valid)
         len <= len + 1'b1;
   end
`else
   assign over_len = 1'b0;
`endif

   always_comb begin
      nxt_state = state;
      nxt_char  = 8'h00;
      nxt_gnt   = gnt_src;
      nxt_rr    = rr_ptr;
      nxt_abort = 1'b0;
      line_end  = 1'b0;
      in_ready  = '0;
      case (state)
         IDLE: begin
            // Non-'^' chars outside a line are consumed and dropped.
            for (int i = 0; i < N; i++)
               in_ready[i] = in_valid[i] && (in_char[8*i +: 8] != CARET);
            if (found) begin
               in_ready[sel] = 1'b1;
               nxt_char      = CARET;
               nxt_gnt       = sel;
               nxt_state     = GRANT;
            end
         end
         GRANT: begin
            in_ready[gnt_src] = g_valid;
            // The checker has no enable, so a gap breaks the line.
            if (!g_valid || over_len) begin
               nxt_abort = 1'b1;
               nxt_state = IDLE;
               nxt_rr    = next_src(gnt_src);
            end else begin
               nxt_char = g_char;
               if (g_char == HASH) begin
                  line_end  = 1'b1;
                  nxt_state = IDLE;
                  nxt_rr    = next_src(gnt_src);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         chk_char  <= 8'h00;
         rr_ptr    <= '0;
         gnt_src   <= '0;
         abort     <= 1'b0;
         cap1_v    <= 1'b0;
         cap1_src  <= '0;
         cap2_v    <= 1'b0;
         cap2_src  <= '0;
         res_valid <= 1'b0;
         res_src   <= '0;
         res_type  <= 2'd0;
      end else begin
         state     <= nxt_state;
         chk_char  <= nxt_char;
         rr_ptr    <= nxt_rr;
         gnt_src   <= nxt_gnt;
         abort     <= nxt_abort;
         // Checker sees '#' one edge after it is sent; sample one later.
         cap1_v    <= line_end;
         cap1_src  <= gnt_src;
         cap2_v    <= cap1_v;
         cap2_src  <= cap1_src;
         res_valid <= cap2_v;
         if (cap2_v) begin
            res_src  <= cap2_src;
            res_type <= chk_type;
         end
      end
   end

endmodule
